// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment driver.
// Segment codes are active-low, bit 0 = a through bit 6 = g.
package seg7_pkg;

    typedef enum logic [1:0] {
        ONES_BLANK = 2'd0,
        ONES_ON    = 2'd1,
        TENS_BLANK = 2'd2,
        TENS_ON    = 2'd3
    } slot_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [0:9][6:0] SEG_TABLE = {
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/seg7_decode.sv
// Decimal digit to active-low 7-segment pattern.
// Non-decimal inputs light nothing.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (digit < 4'd10) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Two-digit multiplexed 7-segment scanner for a 0..15 count, with
// anti-ghost blanking at the start of each digit slot.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50,
    parameter int BLANK_CYC = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] value,
    input  logic       blank_lz,
    output logic [6:0] SEG,
    output logic [1:0] DIG
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);

    generate
        if (BLANK_CYC < 1 || BLANK_CYC > SCAN_DIV - 1) begin : g_bad_param
            $error("seg7_scan_display: need 1 <= BLANK_CYC <= SCAN_DIV-1");
        end
    endgenerate

    slot_state_t   state;
    slot_state_t   state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [3:0]    snap;
    logic [3:0]    ones;
    logic [3:0]    digit;
    logic          tens;
    logic          first;
    logic          last;
    logic [6:0]    seg_dec;
    logic [6:0]    seg_n;
    logic [1:0]    dig_n;

    assign last  = (cnt == LAST);
    assign tens  = (snap >= 4'd10);
    assign ones  = snap - (tens ? 4'd10 : 4'd0);
    assign digit = (state == TENS_ON) ? {3'b000, tens} : ones;

    seg7_decode u_decode (
        .digit (digit),
        .seg   (seg_dec)
    );

    always_comb begin
        cnt_n   = last ? '0 : cnt + CW'(1);
        state_n = state;
        if (last) begin
            state_n = (state == TENS_ON || state == TENS_BLANK)
                    ? ONES_BLANK : TENS_BLANK;
        end else if (cnt_n == BLK) begin
            state_n = (state == TENS_BLANK) ? TENS_ON : ONES_ON;
        end
    end

    // Outputs register the current slot, so edge k shows cycle k of the frame.
    always_comb begin
        seg_n = SEG_OFF;
        dig_n = 2'b11;
        unique case (1'b1)
            (state == ONES_ON): begin
                dig_n = 2'b10;
                seg_n = seg_dec;
            end
            (state == TENS_ON && !(blank_lz && !tens)): begin
                dig_n = 2'b01;
                seg_n = seg_dec;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ONES_BLANK;
            cnt   <= '0;
            snap  <= 4'd0;
            first <= 1'b1;
            SEG   <= SEG_OFF;
            DIG   <= 2'b11;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            first <= 1'b0;
            SEG   <= seg_n;
            DIG   <= dig_n;
            if (first || (state == TENS_ON && last)) begin
                snap <= value;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: directed frames push expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_seg7_scan_display;

    localparam int SD = 50;
    localparam int BC = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] value = 4'd0;
    logic       blank_lz = 1'b0;
    logic [6:0] SEG;
    logic [1:0] DIG;

    seg7_scan_display #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .value    (value),
        .blank_lz (blank_lz),
        .SEG      (SEG),
        .DIG      (DIG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic [1:0] dig;
        int         k;
        bit         fchk;
        int         e1;
        int         e10;
    } exp_t;

    exp_t q[$];
    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Hand-written active-low codes for the ones digit of 0..15.
    logic [6:0] ones_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12
    };

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic step(input logic [3:0] v, input logic blz,
                        input logic rst, input logic [6:0] es,
                        input logic [1:0] ed, input int k, input bit fchk,
                        input int e1, input int e10);
        exp_t e;
        @(negedge CLK);
        value    = v;
        blank_lz = blz;
        RST      = rst;
        e.cyc  = cyc + 1;
        e.seg  = es;
        e.dig  = ed;
        e.k    = k;
        e.fchk = fchk;
        e.e1   = e1;
        e.e10  = e10;
        q.push_back(e);
    endtask

    task automatic frame(input logic [3:0] shown, input logic blz,
                         input logic [3:0] a, input int chg,
                         input logic [3:0] b, input int ncyc);
        logic [6:0] es;
        logic [1:0] ed;
        bit         tblank;
        tblank = blz && (shown < 4'd10);
        for (int k = 0; k < ncyc; k++) begin
            es = 7'h7F;
            ed = 2'b11;
            if (k >= BC && k < SD) begin
                ed = 2'b10;
                es = ones_tab[shown];
            end else if (k >= SD + BC && !tblank) begin
                ed = 2'b01;
                es = (shown >= 4'd10) ? 7'h79 : 7'h40;
            end
            step((k < chg) ? a : b, blz, 1'b0, es, ed, k,
                 (k == 2 * SD - 1), SD - BC, tblank ? 0 : SD - BC);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int c1;
        int c10;
        c1  = 0;
        c10 = 0;
        forever begin
            @(negedge CLK);
            n_cmp++;
            if (DIG === 2'b00) begin
                n_bad++;
                $display("FAIL both_dig cyc=%0d DIG=%b required not 00", cyc, DIG);
            end
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_cmp++;
                if (e.cyc != cyc || SEG !== e.seg || DIG !== e.dig) begin
                    n_bad++;
                    $display("FAIL out k=%0d cyc=%0d SEG=%h DIG=%b required SEG=%h DIG=%b",
                             e.k, e.cyc, SEG, DIG, e.seg, e.dig);
                end
                if (e.k == 0) begin
                    c1  = 0;
                    c10 = 0;
                end
                if (DIG[0] === 1'b0) c1++;
                if (DIG[1] === 1'b0) c10++;
                if (e.fchk) begin
                    n_cmp++;
                    if (c1 != e.e1 || c10 != e.e10) begin
                        n_bad++;
                        $display("FAIL on_count cyc=%0d ones=%0d tens=%0d required %0d/%0d",
                                 e.cyc, c1, c10, e.e1, e.e10);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        for (int i = 0; i < 3; i++) begin
            step(4'd0, 1'b0, 1'b1, 7'h7F, 2'b11, -1, 1'b0, 0, 0);
        end
        frame(4'd7,  1'b0, 4'd7,  99, 4'd13, 100);
        frame(4'd13, 1'b0, 4'd13, 99, 4'd15, 100);
        frame(4'd15, 1'b0, 4'd15, 99, 4'd5,  100);
        frame(4'd5,  1'b1, 4'd5,  99, 4'd3,  100);
        frame(4'd3,  1'b0, 4'd3,  60, 4'd9,  100);
        frame(4'd9,  1'b0, 4'd9,  200, 4'd9, 75);
        step(4'd0, 1'b0, 1'b1, 7'h7F, 2'b11, -1, 1'b0, 0, 0);
        for (int v = 0; v < 16; v++) begin
            frame(4'(v), (v < 8), 4'(v), 99, 4'(v + 1), 100);
        end
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
